// File: rtl/fix_line_fetch.sv
// Fix-layer scanline fetcher: walks NCOLS tile-map entries, fetches two 4-pixel
// ROM words per tile and streams {palette,colour} pixels into the line buffer.
module fix_line_fetch #(
    parameter int NCOLS     = 40,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [7:0]  line_num,
    output logic        vreq,
    output logic [10:0] vaddr,
    input  logic        vack,
    input  logic [15:0] vdata,
    output logic        msreq,
    output logic [16:0] msaddr,
    input  logic        msack,
    input  logic [15:0] msdata,
    output logic        pxwe,
    output logic [8:0]  pxaddr,
    output logic [7:0]  pxdata,
    output logic        busy,
    output logic        done
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam logic [5:0] LAST_COL = 6'(NCOLS - 1);

    typedef enum logic [2:0] {IDLE, MAPREQ, ROMREQ, WRITE, NEXT} state_t;

    state_t      state;
    logic [7:0]  ln;
    logic [5:0]  col;
    logic        half;
    logic [1:0]  k;
    logic [3:0]  pal;
    logic [11:0] tile;
    logic [15:0] word;

    logic [NUM_LANES-1:0][VEC_W-1:0] lane_px;
    logic [NUM_LANES-1:0]            lane_opaque;

    // One lane per pixel slot of the latched ROM word; WRITE picks lane k.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_px[i]     = {pal, word[4*i +: 4]};
        assign lane_opaque[i] = |word[4*i +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ln     <= '0;
            col    <= '0;
            half   <= 1'b0;
            k      <= '0;
            pal    <= '0;
            tile   <= '0;
            word   <= '0;
            vreq   <= 1'b0;
            vaddr  <= '0;
            msreq  <= 1'b0;
            msaddr <= '0;
            pxwe   <= 1'b0;
            pxaddr <= '0;
            pxdata <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            pxwe <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start landing on the done cycle is dropped, not queued.
                    if (line_start && !done) begin
                        ln    <= line_num;
                        col   <= '0;
                        half  <= 1'b0;
                        busy  <= 1'b1;
                        vreq  <= 1'b1;
                        vaddr <= {6'd0, line_num[7:3]};
                        state <= MAPREQ;
                    end
                end
                MAPREQ: begin
                    if (vack) begin
                        vreq   <= 1'b0;
                        pal    <= vdata[15:12];
                        tile   <= vdata[11:0];
                        half   <= 1'b0;
                        msreq  <= 1'b1;
                        msaddr <= {vdata[11:0], ln[2:0], 1'b0, 1'b0};
                        state  <= ROMREQ;
                    end
                end
                ROMREQ: begin
                    if (msack) begin
                        msreq <= 1'b0;
                        word  <= msdata;
                        k     <= '0;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    pxwe   <= !SKIP_ZERO || lane_opaque[k];
                    pxaddr <= {col, half, k};
                    pxdata <= lane_px[k];
                    k      <= k + 2'd1;
                    if (k == 2'd3) begin
                        if (!half) begin
                            half   <= 1'b1;
                            msreq  <= 1'b1;
                            msaddr <= {tile, ln[2:0], 1'b0, 1'b1};
                            state  <= ROMREQ;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (col == LAST_COL) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        col   <= col + 6'd1;
                        half  <= 1'b0;
                        vreq  <= 1'b1;
                        vaddr <= {col + 6'd1, ln[7:3]};
                        state <= MAPREQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
